// File: rtl/kf_matvec_arbiter.sv
// kf_matvec_arbiter
//   Shared 4x4 matrix * 4x1 vector fixed-point engine with a round-robin
//   arbiter in front. Each op computes r = A*b in signed Q(DW-FRAC).FRAC.
//   Every product is truncated (arithmetic shift right by FRAC, then cut to
//   DW bits). The row sums wrap modulo 2^DW.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      asynchronous, active-high reset
//   i_req      per-requester op request (level)
//   i_lock     keep grant after the current op if i_req is also high
//   i_mat_a    per-requester A, row-major, A[r][c] at slot r*4+c,
//              requester k at [k*16*DW +: 16*DW]
//   i_vec_b    per-requester b, b[c] at slot c, requester k at [k*4*DW +: 4*DW]
//   o_gnt      one-hot owner, registered, 0 when idle
//   o_busy     high whenever the engine is not idle
//   o_res      r[0..3], r[i] at [i*DW +: DW], holds until the next op
//   o_res_vld  one-cycle pulse on the owner bit when o_res updates
module kf_matvec_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DW       = 48,
  parameter int FRAC     = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ*16*DW-1:0]  i_mat_a,
  input  logic [N_REQ*4*DW-1:0]   i_vec_b,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_busy,
  output logic [4*DW-1:0]         o_res,
  output logic [N_REQ-1:0]        o_res_vld
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam int PW = 2 * DW;

  typedef enum logic [1:0] {IDLE, LOAD, MULT, SUM} state_t;

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [OW-1:0]     owner, owner_nxt;
  logic [OW-1:0]     last_owner, last_owner_nxt;
  logic [LW-1:0]     lock_cnt, lock_cnt_nxt;

  logic              found;
  logic [OW-1:0]     pick;
  logic [OW-1:0]     cand;

  logic [DW-1:0]         a_q [16];
  logic [DW-1:0]         b_q [4];
  logic signed [PW-1:0]  p_q [16];
  logic [DW-1:0]         r_sum [4];

  // Round-robin search starting just after the previous owner.
  always_comb begin
    found = 1'b0;
    pick  = last_owner;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = OW'((int'(last_owner) + i) % N_REQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = o_gnt;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    lock_cnt_nxt   = lock_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt      = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          owner_nxt    = pick;
          lock_cnt_nxt = '0;
          state_nxt    = LOAD;
        end
      end
      LOAD: state_nxt = MULT;
      MULT: state_nxt = SUM;
      SUM: begin
        lock_cnt_nxt = lock_cnt + 1'b1;
        if (i_req[owner] && i_lock[owner] && ((int'(lock_cnt) + 1) < MAX_LOCK)) begin
          state_nxt = LOAD;
        end else begin
          gnt_nxt        = '0;
          last_owner_nxt = owner;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gnt      <= '0;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);
      lock_cnt   <= '0;
      o_res      <= '0;
      o_res_vld  <= '0;
    end else begin
      o_gnt      <= gnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      o_res_vld  <= '0;
      if (state == SUM) begin
        o_res_vld <= o_gnt;
        for (int unsigned i = 0; i < 4; i++) begin
          o_res[i*DW +: DW] <= r_sum[i];
        end
      end
    end
  end

  // Datapath registers carry no reset; their contents only reach o_res
  // through a complete LOAD/MULT/SUM pass.
  always_ff @(posedge i_clk) begin
    if (state == LOAD) begin
      for (int unsigned k = 0; k < 16; k++) begin
        a_q[k] <= i_mat_a[(int'(owner) * 16 + k) * DW +: DW];
      end
      for (int unsigned c = 0; c < 4; c++) begin
        b_q[c] <= i_vec_b[(int'(owner) * 4 + c) * DW +: DW];
      end
    end
    if (state == MULT) begin
      for (int unsigned k = 0; k < 16; k++) begin
        p_q[k] <= PW'($signed(a_q[k])) * PW'($signed(b_q[k % 4]));
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      r_sum[i] = '0;
      for (int unsigned c = 0; c < 4; c++) begin
        r_sum[i] = r_sum[i] + DW'(p_q[i*4 + c] >>> FRAC);
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_kf_matvec_arbiter.sv
// tb_kf_matvec_arbiter
//   Directed bench for kf_matvec_arbiter (N_REQ=2, DW=48, FRAC=16, MAX_LOCK=4).
//   Expected results are hand-computed Q32.16 constants.
module tb_kf_matvec_arbiter;

  localparam int N_REQ = 2;
  localparam int DW    = 48;
  localparam int RW    = 4 * DW;

  // o_res = {r3, r2, r1, r0}
  localparam logic [RW-1:0] EXP1  = {48'h000000008000, 48'hFFFFFFFD0000,
                                     48'h000000020000, 48'h000000010000};
  localparam logic [RW-1:0] EXP2A = {48'h0, 48'h0, 48'h0, 48'h000000010000};
  localparam logic [RW-1:0] EXP2B = {48'h0, 48'h0, 48'h0, 48'hFFFFFFFFFFFF};
  localparam logic [RW-1:0] EXPR1 = {48'h000000060000, 48'h000000008000,
                                     48'hFFFFFFFE0000, 48'h000000020000};

  logic                   i_clk;
  logic                   i_rst;
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ-1:0]       i_lock;
  logic [N_REQ*16*DW-1:0] i_mat_a;
  logic [N_REQ*4*DW-1:0]  i_vec_b;
  logic [N_REQ-1:0]       o_gnt;
  logic                   o_busy;
  logic [RW-1:0]          o_res;
  logic [N_REQ-1:0]       o_res_vld;

  logic [DW-1:0] A [2][16];
  logic [DW-1:0] B [2][4];

  int checks = 0;
  int errors = 0;

  kf_matvec_arbiter #(.N_REQ(2), .DW(48), .FRAC(16), .MAX_LOCK(4)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_lock    (i_lock),
    .i_mat_a   (i_mat_a),
    .i_vec_b   (i_vec_b),
    .o_gnt     (o_gnt),
    .o_busy    (o_busy),
    .o_res     (o_res),
    .o_res_vld (o_res_vld)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always_comb begin
    i_mat_a = '0;
    i_vec_b = '0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 16; s++) i_mat_a[(k*16 + s)*DW +: DW] = A[k][s];
      for (int c = 0; c < 4; c++)  i_vec_b[(k*4 + c)*DW +: DW]  = B[k][c];
    end
  end

  always @(negedge i_clk) begin
    checks++;
    assert ($onehot0(o_gnt) && $onehot0(o_res_vld)) else begin
      errors++;
      $error("FAIL onehot: observed gnt=%b vld=%b, expected each one-hot or zero", o_gnt, o_res_vld);
    end
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One unlocked op for requester k with only k requesting.
  task automatic do_op(input int k, input logic [RW-1:0] exp, input string tag);
    logic [1:0] bk;
    bk = 2'b01 << k;
    i_req = bk;
    tick();
    chk({tag, "_gnt"}, RW'(o_gnt), RW'(bk));
    chk({tag, "_busy"}, RW'(o_busy), RW'(1'b1));
    i_req = '0;
    tick();
    tick();
    chk({tag, "_novld"}, RW'(o_res_vld), RW'(2'b00));
    tick();
    chk({tag, "_vld"}, RW'(o_res_vld), RW'(bk));
    chk({tag, "_res"}, o_res, exp);
    chk({tag, "_rel"}, RW'(o_gnt), RW'(2'b00));
  endtask

  initial begin
    i_rst  = 1'b1;
    i_req  = '0;
    i_lock = '0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 16; s++) A[k][s] = '0;
      for (int c = 0; c < 4; c++)  B[k][c] = '0;
    end
    #12;
    chk("rst_gnt",  RW'(o_gnt),     RW'(2'b00));
    chk("rst_busy", RW'(o_busy),    RW'(1'b0));
    chk("rst_res",  o_res,          '0);
    chk("rst_vld",  RW'(o_res_vld), RW'(2'b00));

    // 1: identity
    A[0][0] = 48'h10000; A[0][5] = 48'h10000; A[0][10] = 48'h10000; A[0][15] = 48'h10000;
    B[0][0] = 48'h10000; B[0][1] = 48'h20000; B[0][2] = 48'hFFFFFFFD0000; B[0][3] = 48'h8000;
    i_rst = 1'b0;
    i_req = 2'b01;
    tick();
    chk("t1_gnt",  RW'(o_gnt),  RW'(2'b01));
    chk("t1_busy", RW'(o_busy), RW'(1'b1));
    i_req = '0;
    tick();
    chk("t1_e1_vld", RW'(o_res_vld), RW'(2'b00));
    tick();
    chk("t1_e2_vld", RW'(o_res_vld), RW'(2'b00));
    tick();
    chk("t1_vld",  RW'(o_res_vld), RW'(2'b01));
    chk("t1_res",  o_res, EXP1);
    chk("t1_rel",  RW'(o_gnt),  RW'(2'b00));
    chk("t1_idle", RW'(o_busy), RW'(1'b0));
    tick();
    chk("t1_pulse", RW'(o_res_vld), RW'(2'b00));
    chk("t1_hold",  o_res, EXP1);

    // 2: fractional / negative
    for (int s = 0; s < 16; s++) A[0][s] = '0;
    A[0][0] = 48'h8000; A[0][1] = 48'hFFFFFFFFC000;
    B[0][0] = 48'h30000; B[0][1] = 48'h20000; B[0][2] = '0; B[0][3] = '0;
    do_op(0, EXP2A, "t2_frac");
    for (int s = 0; s < 16; s++) A[0][s] = '0;
    A[0][0] = 48'hFFFFFFFF0000;
    B[0][0] = 48'h1; B[0][1] = '0;
    do_op(0, EXP2B, "t2_asr");

    // requester 1 operands: 2.0 * identity
    A[1][0] = 48'h20000; A[1][5] = 48'h20000; A[1][10] = 48'h20000; A[1][15] = 48'h20000;
    B[1][0] = 48'h10000; B[1][1] = 48'hFFFFFFFF0000; B[1][2] = 48'h4000; B[1][3] = 48'h30000;

    // 3: contention from reset
    i_rst = 1'b1;
    i_req = 2'b11;
    tick();
    i_rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] eg;
      eg = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("t3_gnt", RW'(o_gnt), RW'(eg));
      tick();
      tick();
      tick();
      chk("t3_vld", RW'(o_res_vld), RW'(eg));
      chk("t3_res", o_res, (eg == 2'b01) ? EXP2B : EXPR1);
      chk("t3_rel", RW'(o_gnt), RW'(2'b00));
    end

    // 4: lock limit, then lock on non-owner ignored
    i_rst  = 1'b1;
    i_req  = 2'b11;
    i_lock = 2'b01;
    tick();
    i_rst = 1'b0;
    tick();
    chk("t4_gnt", RW'(o_gnt), RW'(2'b01));
    for (int n = 0; n < 4; n++) begin
      tick();
      tick();
      chk("t4_gap", RW'(o_res_vld), RW'(2'b00));
      tick();
      chk("t4_vld",  RW'(o_res_vld), RW'(2'b01));
      chk("t4_keep", RW'(o_gnt),  RW'((n < 3) ? 2'b01 : 2'b00));
      chk("t4_busy", RW'(o_busy), RW'((n < 3) ? 1'b1 : 1'b0));
    end
    tick();
    chk("t4_gnt1", RW'(o_gnt), RW'(2'b10));
    tick();
    tick();
    tick();
    chk("t4_vld1", RW'(o_res_vld), RW'(2'b10));
    chk("t4_res1", o_res, EXPR1);
    chk("t4_rel1", RW'(o_gnt), RW'(2'b00));
    tick();
    chk("t4_gnt0", RW'(o_gnt), RW'(2'b01));

    // 5: request dropped in MULT while lock stays high
    tick();
    i_req = '0;
    tick();
    tick();
    chk("t5_vld",  RW'(o_res_vld), RW'(2'b01));
    chk("t5_res",  o_res, EXP2B);
    chk("t5_rel",  RW'(o_gnt),  RW'(2'b00));
    chk("t5_idle", RW'(o_busy), RW'(1'b0));
    tick();
    chk("t5_pulse", RW'(o_res_vld), RW'(2'b00));
    chk("t5_stay",  RW'(o_gnt),     RW'(2'b00));
    i_lock = '0;

    // 6: reset in MULT
    i_req = 2'b10;
    tick();
    chk("t6_gnt", RW'(o_gnt), RW'(2'b10));
    tick();
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_gnt_clr",  RW'(o_gnt),     RW'(2'b00));
    chk("t6_busy_clr", RW'(o_busy),    RW'(1'b0));
    chk("t6_res_clr",  o_res,          '0);
    chk("t6_vld_clr",  RW'(o_res_vld), RW'(2'b00));
    i_req = '0;
    tick();
    chk("t6_novld", RW'(o_res_vld), RW'(2'b00));
    i_rst = 1'b0;
    do_op(1, EXPR1, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
